// File: rtl/onchip_memory_arbiter.sv
// Two-master arbiter in front of a single-port on-chip memory.
// Define OCM_ARB_ROUND_ROBIN_EN for alternating arbitration; default is fixed m0 priority.
module onchip_memory_arbiter #(
   parameter  int ADDR_W = 11,
   parameter  int DATA_W = 32,
   localparam int BE_W   = DATA_W / 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reset_req,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              mem_clken,
   output logic              mem_reset_req,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic {IDLE, RD_RET} state_t;

   state_t            state, state_nxt;
   logic              rd_owner, rd_owner_nxt;
   logic              last_grant, last_grant_nxt;
   logic [ADDR_W-1:0] hold_address;
   logic [BE_W-1:0]   hold_byteenable;
   logic [DATA_W-1:0] hold_writedata;

   logic              act0, act1, allow, pick1;
   logic              gnt0, gnt1, granted;
   logic              sel_write, rd_issue, rd_valid;
   logic [ADDR_W-1:0] sel_address;
   logic [BE_W-1:0]   sel_byteenable;
   logic [DATA_W-1:0] sel_writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         rd_owner        <= 1'b0;
         last_grant      <= 1'b1;
         hold_address    <= '0;
         hold_byteenable <= '0;
         hold_writedata  <= '0;
      end else begin
         state      <= state_nxt;
         rd_owner   <= rd_owner_nxt;
         last_grant <= last_grant_nxt;
         if (granted) begin
            hold_address    <= sel_address;
            hold_byteenable <= sel_byteenable;
            hold_writedata  <= sel_writedata;
         end
      end
   end

   always_comb begin
      act0  = m0_read | m0_write;
      act1  = m1_read | m1_write;
      allow = ~reset & ~reset_req;
`ifdef OCM_ARB_ROUND_ROBIN_EN
      pick1 = ~last_grant;
`else
      pick1 = 1'b0;
`endif
      // On contention pick1 selects m1, otherwise m0 takes the slot
      gnt0    = allow & act0 & ~(act1 & pick1);
      gnt1    = allow & act1 & ~(act0 & ~pick1);
      granted = gnt0 | gnt1;

      sel_write      = gnt1 ? m1_write      : m0_write;
      sel_address    = gnt1 ? m1_address    : m0_address;
      sel_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
      sel_writedata  = gnt1 ? m1_writedata  : m0_writedata;

      rd_issue       = granted & ~sel_write;
      state_nxt      = rd_issue ? RD_RET : IDLE;
      rd_owner_nxt   = rd_issue ? gnt1 : rd_owner;
      last_grant_nxt = granted ? gnt1 : last_grant;

      // A synchronous reset in the return cycle drops the pending read
      rd_valid         = (state == RD_RET) & ~reset;
      m0_readdatavalid = rd_valid & ~rd_owner;
      m1_readdatavalid = rd_valid & rd_owner;
      m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
      m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

      m0_waitrequest = act0 & ~gnt0;
      m1_waitrequest = act1 & ~gnt1;

      mem_chipselect = granted;
      mem_write      = granted & sel_write;
      mem_address    = hold_address;
      mem_byteenable = hold_byteenable;
      mem_writedata  = hold_writedata;
      if (granted) begin
         mem_address    = sel_address;
         mem_byteenable = sel_byteenable;
         mem_writedata  = sel_writedata;
      end else if (reset) begin
         mem_address    = '0;
         mem_byteenable = '0;
         mem_writedata  = '0;
      end
      mem_clken     = 1'b1;
      mem_reset_req = reset_req;
   end

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Bench for onchip_memory_arbiter: directed table, corner sequences,
// and random traffic against a transaction-level reference model.
module tb_onchip_memory_arbiter;

`ifdef OCM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0, reset_req = 1'b0;
   logic [10:0] m0_address = '0, m1_address = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0;
   logic        m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [10:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
   logic [31:0] mem_readdata = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem    [2048];
   logic [31:0] refmem [2048];

   always #5 clk = ~clk;

   onchip_memory_arbiter dut (
      .clk(clk), .reset(reset), .reset_req(reset_req),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable),
      .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_clken(mem_clken),
      .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
   );

   // Memory slave: byte-enabled write, one-cycle read latency
   always @(posedge clk) begin
      if (mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < 4; b++)
               if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= mem[mem_address];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic rq,
                        input logic r0, input logic w0, input logic [10:0] a0,
                        input logic [31:0] d0, input logic [3:0] be0,
                        input logic r1, input logic w1, input logic [10:0] a1,
                        input logic [31:0] d1, input logic [3:0] be1);
      reset = rst; reset_req = rq;
      m0_read = r0; m0_write = w0; m0_address = a0;
      m0_writedata = d0; m0_byteenable = be0;
      m1_read = r1; m1_write = w1; m1_address = a1;
      m1_writedata = d1; m1_byteenable = be1;
   endtask

   task automatic chk_core(input string t,
                           input logic x_w0, input logic x_w1,
                           input logic x_cs, input logic x_wr,
                           input logic [10:0] x_addr,
                           input logic x_v0, input logic x_v1,
                           input logic [31:0] x_d0, input logic [31:0] x_d1);
      chk({t, ".wait0"}, {31'd0, m0_waitrequest}, {31'd0, x_w0});
      chk({t, ".wait1"}, {31'd0, m1_waitrequest}, {31'd0, x_w1});
      chk({t, ".cs"},    {31'd0, mem_chipselect}, {31'd0, x_cs});
      chk({t, ".wr"},    {31'd0, mem_write},      {31'd0, x_wr});
      chk({t, ".addr"},  {21'd0, mem_address},    {21'd0, x_addr});
      chk({t, ".rdv0"},  {31'd0, m0_readdatavalid}, {31'd0, x_v0});
      chk({t, ".rdv1"},  {31'd0, m1_readdatavalid}, {31'd0, x_v1});
      chk({t, ".rd0"},   m0_readdata, x_d0);
      chk({t, ".rd1"},   m1_readdata, x_d1);
      chk({t, ".rreq"},  {31'd0, mem_reset_req}, {31'd0, reset_req});
      chk({t, ".clken"}, {31'd0, mem_clken}, 32'd1);
   endtask

   typedef struct {
      logic rst, rq;
      logic r0, w0; logic [10:0] a0; logic [31:0] d0; logic [3:0] be0;
      logic r1, w1; logic [10:0] a1; logic [31:0] d1; logic [3:0] be1;
      logic x_w0, x_w1, x_cs, x_wr; logic [10:0] x_addr;
      logic x_v0, x_v1; logic [31:0] x_d0, x_d1;
   } vec_t;

   vec_t tbl [17];

   int          exp_g [4];
   int          last, owner, g;
   bit          pend;
   logic [31:0] pdata;
   logic [10:0] h_addr;
   logic [3:0]  h_be;
   logic [31:0] h_wd;

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      //           rst rq r0 w0 a0     d0            be0  r1 w1 a1     d1            be1  | w0 w1 cs wr addr  v0 v1 d0 d1
      tbl[0]  = '{1, 0, 0, 1, 11'h005, 32'h0,        4'h0, 1, 0, 11'h0, 32'h0,       4'h0, 1, 1, 0, 0, 11'h000, 0, 0, 32'h0, 32'h0};
      tbl[1]  = '{0, 0, 0, 1, 11'h005, 32'hDEADBEEF, 4'hF, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 1, 1, 11'h005, 0, 0, 32'h0, 32'h0};
      tbl[2]  = '{0, 0, 1, 0, 11'h005, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 1, 0, 11'h005, 0, 0, 32'h0, 32'h0};
      tbl[3]  = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 0, 0, 11'h005, 1, 0, 32'hDEADBEEF, 32'h0};
      tbl[4]  = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 1, 11'h7FF, 32'h12345678, 4'h3, 0, 0, 1, 1, 11'h7FF, 0, 0, 32'h0, 32'h0};
      tbl[5]  = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 0, 0, 11'h7FF, 0, 0, 32'h0, 32'h0};
      tbl[6]  = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h7FF, 32'h0,     4'h0, 0, 0, 1, 0, 11'h7FF, 0, 0, 32'h0, 32'h0};
      tbl[7]  = '{0, 0, 0, 1, 11'h010, 32'hA5A5A5A5, 4'hF, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 1, 1, 11'h010, 0, 1, 32'h0, 32'h00005678};
      tbl[8]  = '{0, 1, 0, 1, 11'h020, 32'h11111111, 4'hF, 0, 0, 11'h0, 32'h0,       4'h0, 1, 0, 0, 0, 11'h010, 0, 0, 32'h0, 32'h0};
      tbl[9]  = tbl[8];
      tbl[10] = tbl[8];
      tbl[11] = '{0, 0, 0, 1, 11'h020, 32'h11111111, 4'hF, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 1, 1, 11'h020, 0, 0, 32'h0, 32'h0};
      tbl[12] = '{0, 0, 1, 0, 11'h020, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 1, 0, 11'h020, 0, 0, 32'h0, 32'h0};
      tbl[13] = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 0, 0, 11'h020, 1, 0, 32'h11111111, 32'h0};
      tbl[14] = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 1, 0, 11'h010, 32'h0,     4'h0, 0, 0, 1, 0, 11'h010, 0, 0, 32'h0, 32'h0};
      tbl[15] = '{0, 1, 1, 0, 11'h005, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 1, 0, 0, 0, 11'h010, 0, 1, 32'h0, 32'hA5A5A5A5};
      tbl[16] = '{0, 0, 0, 0, 11'h000, 32'h0,        4'h0, 0, 0, 11'h0, 32'h0,       4'h0, 0, 0, 0, 0, 11'h010, 0, 0, 32'h0, 32'h0};

      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #1;
         drive(tbl[i].rst, tbl[i].rq, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].be0,
               tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, tbl[i].be1);
         #1;
         chk_core($sformatf("tbl%0d", i), tbl[i].x_w0, tbl[i].x_w1, tbl[i].x_cs, tbl[i].x_wr,
                  tbl[i].x_addr, tbl[i].x_v0, tbl[i].x_v1, tbl[i].x_d0, tbl[i].x_d1);
      end

      // Both masters read continuously for four cycles after a reset
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) exp_g[k] = RR ? (k % 2) : 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k < 4) drive(0, 0, 1, 0, 11'h005, 0, 0, 1, 0, 11'h7FF, 0, 0);
         else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         #1;
         if (k < 4) begin
            chk($sformatf("both%0d.wait0", k), {31'd0, m0_waitrequest}, {31'd0, exp_g[k] != 0});
            chk($sformatf("both%0d.wait1", k), {31'd0, m1_waitrequest}, {31'd0, exp_g[k] != 1});
         end
         if (k > 0) begin
            chk($sformatf("both%0d.rdv0", k), {31'd0, m0_readdatavalid}, {31'd0, exp_g[k-1] == 0});
            chk($sformatf("both%0d.rdv1", k), {31'd0, m1_readdatavalid}, {31'd0, exp_g[k-1] == 1});
            chk($sformatf("both%0d.rd0", k), m0_readdata, exp_g[k-1] == 0 ? 32'hDEADBEEF : 32'h0);
            chk($sformatf("both%0d.rd1", k), m1_readdata, exp_g[k-1] == 1 ? 32'h00005678 : 32'h0);
         end
      end

      // Reset lands in the return cycle of an m1 read
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 11'h7FF, 0, 0);
      #1;
      chk_core("rstrd.issue", 0, 0, 1, 0, 11'h7FF, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_core("rstrd.rst", 0, 0, 0, 0, 11'h000, 0, 0, 32'h0, 32'h0);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk_core("rstrd.after", 0, 0, 0, 0, 11'h000, 0, 0, 32'h0, 32'h0);

      // Random traffic against the reference model
      for (int i = 0; i < 2048; i++) refmem[i] = mem[i];
      last = 1; owner = 0; pend = 0; pdata = '0;
      h_addr = '0; h_be = '0; h_wd = '0;
      for (int c = 0; c < 500; c++) begin
         int op0, op1;
         logic rst, rq, a0, a1, wr_g;
         logic [10:0] ad_g;
         logic [3:0]  be_g;
         logic [31:0] wd_g;
         @(posedge clk); #1;
         op0 = $urandom_range(0, 3);
         op1 = $urandom_range(0, 3);
         rst = (c == 0) || ($urandom_range(0, 49) == 0);
         rq  = ($urandom_range(0, 9) == 0);
         drive(rst, rq, op0[0], op0[1], 11'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
               op1[0], op1[1], 11'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         #1;
         a0 = m0_read | m0_write;
         a1 = m1_read | m1_write;
         g = -1;
         if (!rst && !rq) begin
            if (a0 && a1)  g = (RR && last == 0) ? 1 : 0;
            else if (a0)   g = 0;
            else if (a1)   g = 1;
         end
         wr_g = (g == 1) ? m1_write : m0_write;
         ad_g = (g == 1) ? m1_address : m0_address;
         be_g = (g == 1) ? m1_byteenable : m0_byteenable;
         wd_g = (g == 1) ? m1_writedata : m0_writedata;
         chk_core($sformatf("rnd%0d", c), a0 && g != 0, a1 && g != 1, g >= 0, g >= 0 && wr_g,
                  g >= 0 ? ad_g : (rst ? 11'h0 : h_addr),
                  pend && owner == 0 && !rst, pend && owner == 1 && !rst,
                  (pend && owner == 0 && !rst) ? pdata : 32'h0,
                  (pend && owner == 1 && !rst) ? pdata : 32'h0);
         chk($sformatf("rnd%0d.be", c), {28'd0, mem_byteenable},
             {28'd0, g >= 0 ? be_g : (rst ? 4'h0 : h_be)});
         chk($sformatf("rnd%0d.wd", c), mem_writedata, g >= 0 ? wd_g : (rst ? 32'h0 : h_wd));
         if (rst) begin
            last = 1; owner = 0; pend = 0;
            h_addr = '0; h_be = '0; h_wd = '0;
         end else begin
            pend = 0;
            if (g >= 0) begin
               last = g; h_addr = ad_g; h_be = be_g; h_wd = wd_g;
               if (wr_g) begin
                  for (int b = 0; b < 4; b++)
                     if (be_g[b]) refmem[ad_g][8*b +: 8] = wd_g[8*b +: 8];
               end else begin
                  pend = 1; owner = g; pdata = refmem[ad_g];
               end
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
